serial_link_ctrl: RTL and testbench
===================================

SERIAL_LINK_CTRL -- requirements
Module: serial_link_ctrl

Interface
REQ-001 Parameter: GAP_CYCLES, default 2, number of idle-low bit times forced after every frame (legal range 2..15).
REQ-002 clk  input  1  single clock for all logic; bit time = one clk cycle.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  2  per-requester transmit request; req[i] held high with data_i stable until ack[i].
REQ-005 data0  input  32  payload of requester 0.
REQ-006 data1  input  32  payload of requester 1.
REQ-007 ack  output  2  one-cycle, one-hot grant/latch acknowledge, registered.
REQ-008 busy  output  1  high while any frame or gap is in progress (state != IDLE).
REQ-009 sdo  output  1  serial line to the deserializer, registered, idle low.
REQ-010 frame_done  output  1  one-cycle pulse in the last gap cycle of each frame.
REQ-011 Clock is clk; reset is rst, asynchronous and active-high; only one clock domain.

Function
REQ-012 FSM states: IDLE, HDR, DATA, PAR (only with PARITY_EN), GAP; encoding is implementation choice.
REQ-013 IDLE: sdo=0, busy=0; on a clk edge with req!=0, grant one requester, latch its data into a 32-bit shift register, go to HDR.
REQ-014 Arbitration: round-robin; a last-grant pointer selects the other requester first when both request; single requester always wins; pointer updates only on grant.
REQ-015 ack[g] is high for exactly the one cycle following the grant edge; never two ack bits high; no ack outside that cycle.
REQ-016 Requester deasserts req on the edge ending its ack cycle; a req still high when FSM returns to IDLE is treated as a new request.
REQ-017 HDR: sdo=1 for 2 cycles (sync pattern "11"), then DATA.
REQ-018 DATA: 32 cycles, sdo = latched word MSB first (bit 31 in first DATA cycle, bit 0 in last); 5-bit counter 0..31, wraps to 0 on exit.
REQ-019 GAP: sdo=0 for GAP_CYCLES cycles; frame_done pulses in the final GAP cycle; then IDLE.
REQ-020 Latency: grant edge to first header bit on sdo = 0 cycles (sdo registered at grant edge); min grant-to-grant spacing = 34 + GAP_CYCLES (+1 with PARITY_EN) cycles.
REQ-021 Requests arriving while busy are ignored until IDLE; data changes on a non-granted input never affect a frame in flight.
REQ-022 req changes during HDR/DATA/PAR/GAP SHALL not alter sdo, ack or counter.

Reset
REQ-023 rst high: immediately (asynchronously) sdo=0, ack=00, busy=0, frame_done=0, state=IDLE, counters=0, shift register=0, last-grant pointer=1 (requester 0 wins first contended grant).
REQ-024 rst asserted mid-frame aborts the frame with no gap or frame_done; first grant after rst release occurs on the first clk edge with rst low and req!=0.

Configuration
REQ-025 Macro SERIAL_PARITY_EN: when defined, one PAR cycle follows DATA with sdo = even parity (XOR of the 32 latched bits); frame = 35 bits + gap.
REQ-026 Without SERIAL_PARITY_EN: no PAR state, DATA goes directly to GAP; frame = 34 bits + gap; port list identical in both builds.

Verification
REQ-027 rst pulse mid-DATA of a frame -> sdo=0, busy=0, ack=00 within same cycle; after release, req=01 gives full new frame.
REQ-028 req=01, data0=32'hA5A5_0001, GAP_CYCLES=2 -> ack=01 one cycle; sdo = 1,1, then A5A50001 MSB first, then 0,0; frame_done in 36th cycle; busy low after.
REQ-029 req=11 held continuously, data0=32'h0, data1=32'hFFFF_FFFF -> grants alternate 0,1,0,1; grants spaced 36 cycles (37 with parity).
REQ-030 req=10 asserted during a frame for requester 0 -> no ack until IDLE; then ack=10 on first IDLE edge.
REQ-031 SERIAL_PARITY_EN build, data0=32'h0000_0007 -> PAR bit =1; data0=32'h0000_0003 -> PAR bit =0; frame_done in 37th cycle.
REQ-032 Loopback sdo into the deserializer: for 100 random words, the captured 32-bit output matches the sent words in order.

Source files
------------

// File: rtl/serial_link_ctrl.sv
// ---------------------------------------------------------------------------
// serial_link_ctrl
//
// Two-requester serial frame transmitter. A round-robin arbiter grants one
// requester, latches its 32-bit payload and shifts it out on a single wire
// as a frame:
//   "11" sync header, 32 data bits MSB first, [optional even-parity bit],
//   then GAP_CYCLES idle-low bit times.
// One bit per clk cycle. sdo idles low.
//
// Configuration macro:
//   SERIAL_PARITY_EN  when defined, one parity bit (XOR of the 32 payload
//                     bits) is sent between the last data bit and the gap.
//                     The port list is the same in both builds.
//
// Parameters:
//   GAP_CYCLES  idle-low bit times after every frame (legal 2..15)
//
// Ports:
//   clk         single clock, one bit time per cycle
//   rst         asynchronous, active-high reset
//   req[1:0]    per-requester transmit request, held until ack
//   data0       payload of requester 0 (stable while req[0] high)
//   data1       payload of requester 1 (stable while req[1] high)
//   ack[1:0]    one-cycle one-hot acknowledge, in the cycle after the grant
//   busy        high whenever the FSM is not IDLE
//   sdo         registered serial output
//   frame_done  one-cycle pulse in the last gap cycle of each frame
// ---------------------------------------------------------------------------
module serial_link_ctrl #(
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    output logic [1:0]  ack,
    output logic        busy,
    output logic        sdo,
    output logic        frame_done
);

    localparam int DATA_W = 32;

    // Gap counter values for the last gap cycle and the one before it.
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
    localparam logic [3:0] GAP_PEN  = 4'(GAP_CYCLES - 2);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        PAR  = 3'd3,
        GAP  = 3'd4
    } state_t;

    state_t              state;
    logic [4:0]          bit_cnt;
    logic [3:0]          gap_cnt;
    logic [DATA_W-1:0]   shreg;
    logic                last_grant;

`ifdef SERIAL_PARITY_EN
    logic                par_bit;

    function automatic logic even_parity(input logic [DATA_W-1:0] w);
        return ^w;
    endfunction
`endif

    logic                grant_sel;
    logic                start;
    logic [DATA_W-1:0]   grant_word;

    // Round-robin pick: when both request, the one not granted last wins.
    always_comb begin
        grant_sel = 1'b0;
        case (req)
            2'b10:   grant_sel = 1'b1;
            2'b11:   grant_sel = ~last_grant;
            default: grant_sel = 1'b0;
        endcase
    end

    assign grant_word = grant_sel ? data1 : data0;

    // A request is accepted in IDLE, and also on the edge that ends the last
    // gap cycle, which is the edge on which the FSM returns to IDLE. That
    // keeps back-to-back frames at the minimum spacing of one frame + gap.
    assign start = (req != 2'b00) &&
                   ((state == IDLE) || ((state == GAP) && (gap_cnt == GAP_LAST)));

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sdo        <= 1'b0;
            ack        <= 2'b00;
            frame_done <= 1'b0;
            bit_cnt    <= 5'd0;
            gap_cnt    <= 4'd0;
            shreg      <= '0;
            last_grant <= 1'b1;
`ifdef SERIAL_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            ack        <= 2'b00;
            frame_done <= 1'b0;

            if (start) begin
                // Grant edge: first header bit goes out in the very next cycle.
                state      <= HDR;
                sdo        <= 1'b1;
                bit_cnt    <= 5'd0;
                gap_cnt    <= 4'd0;
                shreg      <= grant_word;
                last_grant <= grant_sel;
                ack        <= grant_sel ? 2'b10 : 2'b01;
`ifdef SERIAL_PARITY_EN
                par_bit    <= even_parity(grant_word);
`endif
            end else begin
                case (state)
                    IDLE: begin
                        sdo <= 1'b0;
                    end

                    HDR: begin
                        if (bit_cnt == 5'd0) begin
                            sdo     <= 1'b1;
                            bit_cnt <= 5'd1;
                        end else begin
                            // Second header cycle ends: present bit 31.
                            sdo     <= shreg[DATA_W-1];
                            shreg   <= {shreg[DATA_W-2:0], 1'b0};
                            bit_cnt <= 5'd0;
                            state   <= DATA;
                        end
                    end

                    DATA: begin
                        if (bit_cnt == 5'd31) begin
                            bit_cnt <= 5'd0;
`ifdef SERIAL_PARITY_EN
                            sdo     <= par_bit;
                            state   <= PAR;
`else
                            sdo     <= 1'b0;
                            gap_cnt <= 4'd0;
                            state   <= GAP;
`endif
                        end else begin
                            sdo     <= shreg[DATA_W-1];
                            shreg   <= {shreg[DATA_W-2:0], 1'b0};
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end

                    PAR: begin
                        sdo     <= 1'b0;
                        gap_cnt <= 4'd0;
                        state   <= GAP;
                    end

                    GAP: begin
                        sdo <= 1'b0;
                        if (gap_cnt == GAP_LAST) begin
                            gap_cnt <= 4'd0;
                            state   <= IDLE;
                        end else begin
                            gap_cnt    <= gap_cnt + 4'd1;
                            frame_done <= (gap_cnt == GAP_PEN);
                        end
                    end

                    default: begin
                        sdo   <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_link_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_link_ctrl
//
// Directed bench for serial_link_ctrl: reset values, a single frame with a
// known word, round-robin alternation under continuous contention, a request
// arriving mid-frame, asynchronous reset mid-frame, parity words and a
// loopback of 100 random words through a bit-capturing deserializer model.
// ---------------------------------------------------------------------------
module tb_serial_link_ctrl;

    localparam int GAP = 2;
`ifdef SERIAL_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FL = 34 + GAP + PB;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [31:0] data0;
    logic [31:0] data1;
    logic [1:0]  ack;
    logic        busy;
    logic        sdo;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_link_ctrl #(.GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data0      (data0),
        .data1      (data1),
        .ack        (ack),
        .busy       (busy),
        .sdo        (sdo),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line contents of one frame, first bit in the MSB position.
    function automatic logic [63:0] exp_stream(input logic [31:0] w);
        logic [63:0] e;
        e = (64'h3 << 32) | {32'h0, w};
        if (PB == 1) e = (e << 1) | {63'h0, ^w};
        e = e << GAP;
        return e;
    endfunction

    // Starts just before a grant edge; ends in the last gap cycle of the frame.
    // rx is what a deserializer on sdo captures from the data bit times.
    task automatic run_frame(input string tag, input logic [1:0] gnt,
                             input logic [31:0] w, input bit hold,
                             output logic [31:0] rx);
        logic [63:0] got;
        logic [1:0]  ack_x;
        int          fd_at;
        int          fd_n;
        got   = 64'h0;
        ack_x = 2'b00;
        fd_at = -1;
        fd_n  = 0;
        for (int c = 1; c <= FL; c++) begin
            tick();
            got = {got[62:0], sdo};
            if (frame_done) begin
                fd_n++;
                fd_at = c;
            end
            if (c == 1) begin
                check({tag, "_ack"}, {62'h0, ack}, {62'h0, gnt});
                check({tag, "_busy"}, {63'h0, busy}, 64'h1);
            end else begin
                ack_x = ack_x | ack;
            end
            if (c == 2 && !hold) req = req & ~gnt;
        end
        check({tag, "_sdo"}, got, exp_stream(w));
        check({tag, "_fd_at"}, 64'(fd_at), 64'(FL));
        check({tag, "_fd_n"}, 64'(fd_n), 64'd1);
        check({tag, "_ack_x"}, {62'h0, ack_x}, 64'h0);
        rx = got[GAP+PB +: 32];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rx;
        logic [31:0] w;
        logic [1:0]  ack_x;

        // Reset values, asserted before any clock edge.
        rst   = 1'b1;
        req   = 2'b00;
        data0 = 32'h0;
        data1 = 32'h0;
        #3;
        check("rst_out", {60'h0, sdo, ack, busy, frame_done}, 64'h0);
        tick();
        tick();
        rst = 1'b0;

        // Single frame, known word.
        data0 = 32'hA5A5_0001;
        req   = 2'b01;
        run_frame("f028", 2'b01, data0, 1'b0, rx);
        tick();
        check("f028_idle", {61'h0, busy, ack}, 64'h0);
        check("f028_sdo0", {63'h0, sdo}, 64'h0);

        // Lone requester 0 wins although the pointer favours requester 1.
        data0 = 32'h0F0F_1234;
        req   = 2'b01;
        run_frame("single", 2'b01, data0, 1'b0, rx);
        tick();

        // Continuous contention after reset: 0,1,0,1 back to back.
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        data0 = 32'h0000_0000;
        data1 = 32'hFFFF_FFFF;
        req   = 2'b11;
        for (int k = 0; k < 4; k++) begin
            run_frame($sformatf("rr%0d", k), (k % 2 == 0) ? 2'b01 : 2'b10,
                      (k % 2 == 0) ? data0 : data1, 1'b1, rx);
        end
        req = 2'b00;
        tick();
        check("rr_idle", {63'h0, busy}, 64'h0);

        // Requester 1 arrives during a frame for requester 0.
        data0 = 32'h1357_9BDF;
        req   = 2'b01;
        tick();
        check("late_ack0", {62'h0, ack}, 64'h1);
        req   = 2'b10;
        ack_x = 2'b00;
        for (int c = 2; c <= FL; c++) begin
            tick();
            ack_x = ack_x | ack;
        end
        check("late_noack", {62'h0, ack_x}, 64'h0);
        tick();
        check("late_ack1", {62'h0, ack}, 64'h2);
        tick();
        req = 2'b00;

        // Now mid-DATA of requester 1's all-ones frame: asynchronous reset.
        for (int c = 0; c < 8; c++) tick();
        check("mid_sdo_pre", {63'h0, sdo}, 64'h1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out", {60'h0, sdo, ack, busy, frame_done}, 64'h0);
        tick();
        check("arst_hold", {60'h0, sdo, ack, busy, frame_done}, 64'h0);
        rst   = 1'b0;
        data0 = 32'h8000_0001;
        req   = 2'b01;
        run_frame("post_rst", 2'b01, data0, 1'b0, rx);
        tick();

        // Parity words (parity bit present only in the parity build).
        data0 = 32'h0000_0007;
        req   = 2'b01;
        run_frame("par7", 2'b01, data0, 1'b0, rx);
        data0 = 32'h0000_0003;
        req   = 2'b01;
        run_frame("par3", 2'b01, data0, 1'b0, rx);
        tick();

        // Loopback of random words, alternating single requesters.
        for (int i = 0; i < 100; i++) begin
            w = $urandom;
            if (i % 2 == 0) begin
                data0 = w;
                req   = 2'b01;
                run_frame($sformatf("lb%0d", i), 2'b01, w, 1'b0, rx);
            end else begin
                data1 = w;
                req   = 2'b10;
                run_frame($sformatf("lb%0d", i), 2'b10, w, 1'b0, rx);
            end
            check($sformatf("lb%0d_rx", i), {32'h0, rx}, {32'h0, w});
        end
        tick();
        check("end_idle", {63'h0, busy}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
